add_seq_ctrl: RTL and testbench



---
 rtl/add_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_add_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-precision add/subtract sequencer.
// A single 4-bit ripple-carry slice (four bitsum cells) is time-shared
// across NIBBLES cycles, LSB nibble first, with the carry chained through
// a register between steps. Results leave over a valid/ready handshake.

// bitsum: one full-adder cell of the ripple-carry slice.
module bitsum (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;      // already inverted for subtract
  logic [W-1:0]    sum_reg;
  logic            carry_reg;
  logic [IDXW-1:0] idx_reg;
  logic            cout_reg;
  logic            ovf_reg;

  logic            accept;
  logic            last_step;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      s_nib;
  logic            slice_cout;

  assign accept    = in_valid && (state_reg == IDLE);
  assign last_step = (state_reg == RUN) && (idx_reg == LAST_IDX);

  // Current nibble of each operand feeds the shared slice.
  assign a_nib = a_reg[{idx_reg, 2'b00} +: 4];
  assign b_nib = b_reg[{idx_reg, 2'b00} +: 4];

  // Ripple chain: each cell owns its carry nets so no vector feeds itself.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cell
    logic ci;
    logic co;
    if (gi == 0) begin : g_first
      assign ci = carry_reg;
    end else begin : g_rest
      assign ci = g_cell[gi-1].co;
    end
    bitsum u_bitsum (
      .a    (a_nib[gi]),
      .b    (b_nib[gi]),
      .cin  (ci),
      .s    (s_nib[gi]),
      .cout (co)
    );
  end

  assign slice_cout = g_cell[3].co;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one nibble step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= in_a;
      b_reg     <= in_sub ? ~in_b : in_b;
      carry_reg <= in_sub;  // +1 completes the two's-complement negate
      idx_reg   <= '0;
      sum_reg   <= '0;
    end else if (state_reg == RUN) begin
      sum_reg[{idx_reg, 2'b00} +: 4] <= s_nib;
      carry_reg <= slice_cout;
      idx_reg   <= idx_reg + 1'b1;
      if (last_step) begin
        cout_reg <= slice_cout;
        // Overflow: like-signed operands producing a differently-signed result.
        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (s_nib[3] != a_reg[W-1]);
      end
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;
  assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Testbench for add_seq_ctrl: directed cases with literal expectations,
// backpressure and mid-run reset, then randomized traffic checked every
// cycle against an arithmetic reference model.
module tb_add_seq_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks = 0;
  int failures = 0;

  // Reference model state: cycles remaining until the result, and result.
  int           m_cnt = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] e_sum = '0;
  logic         e_cout = 1'b0;
  logic         e_ovf = 1'b0;

  add_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Plain integer arithmetic: unsigned result/carry and signed range test.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] s, output logic c, output logic o);
    longint ua, ub, sa, sb, r, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r  = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      r  = ua + ub;
      sr = sa + sb;
      c  = (r >= (64'sd1 <<< W));
    end
    s = r[W-1:0];
    o = (sr > SMAX) || (sr < SMIN);
  endfunction

  // Model: accept when idle, result appears NIBBLES edges later, held until taken.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt   = 0;
        m_valid = 1'b0;
      end else if (m_valid) begin
        if (out_ready) m_valid = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_valid = 1'b1;
      end else if (in_valid) begin
        ref_op(in_a, in_b, in_sub, e_sum, e_cout, e_ovf);
        m_cnt = NIBBLES;
      end
    end
  end

  // Compare DUT against model every cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(!m_valid && m_cnt == 0));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
          chk("out_sum", 32'(out_sum), 32'(e_sum));
          chk("out_cout", 32'(out_cout), 32'(e_cout));
          chk("out_ovf", 32'(out_ovf), 32'(e_ovf));
        end
      end
    end
  end

  // One directed operation with literal expectations and latency check.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] esum, input logic ecout, input logic eovf);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n - 1), 32'(NIBBLES));
    chk("dir_sum", 32'(out_sum), 32'(esum));
    chk("dir_cout", 32'(out_cout), 32'(ecout));
    chk("dir_ovf", 32'(out_ovf), 32'(eovf));
    $display("op a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d", a, b, sub, out_sum, out_cout, out_ovf);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_cout", 32'(out_cout), 32'd0);
    chk("reset_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Backpressure: result held while a new request waits
    in_a = 16'h1234; in_b = 16'h0FFF; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_a = 16'h4000; in_b = 16'h0001; in_sub = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_sum", 32'(out_sum), 32'h2233);
    end
    $display("backpressure held sum=%h", out_sum);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_sum", 32'(out_sum), 32'h3FFF);
    chk("bp_cout", 32'(out_cout), 32'd1);
    chk("bp_ovf", 32'(out_ovf), 32'd0);
    $display("backpressure next op sum=%h cout=%0d", out_sum, out_cout);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of RUN (idx=2, partial sum nonzero)
    in_a = 16'h1111; in_b = 16'h1111; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_cout", 32'(out_cout), 32'd0);
    chk("mid_rst_ovf", 32'(out_ovf), 32'd0);
    $display("mid-run reset applied");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Randomized traffic checked by the per-cycle compare
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (in_valid && in_ready)
        $display("rand accept a=%h b=%h sub=%0d", in_a, in_b, in_sub);
      in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: in_a = 16'h0000;
        1: in_a = 16'hFFFF;
        2: in_a = 16'h7FFF;
        3: in_a = 16'h8000;
        default: in_a = W'($urandom);
      endcase
      in_b      = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NIBBLES + 3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
